dual_port_ram_be: RTL and testbench



---
 rtl/ram_pkg.sv | 29 ++
 rtl/ram_output_stage.sv | 30 +++
 rtl/dual_port_ram_be.sv | 137 +++++++++++++
 tb/tb_dual_port_ram_be.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/ram_pkg.sv
// Shared constants and lane helpers for the std/mem inferred RAM family.
// Lane merges are done at a fixed maximum width and cast down by callers.
package ram_pkg;

    localparam int READ_FIRST  = 0;
    localparam int WRITE_FIRST = 1;
    localparam int NO_CHANGE   = 2;

    localparam int MAX_WIDTH = 256;

    function automatic int lanes(input int width, input int byteWidth);
        return width / byteWidth;
    endfunction

    function automatic logic [MAX_WIDTH-1:0] mergeLanes(
        input logic [MAX_WIDTH-1:0] old_word,
        input logic [MAX_WIDTH-1:0] new_word,
        input logic [MAX_WIDTH-1:0] mask,
        input int                   byteWidth
    );
        logic [MAX_WIDTH-1:0] merged;
        merged = old_word;
        for (int i = 0; i < MAX_WIDTH; i++) begin
            if (mask[i / byteWidth]) merged[i] = new_word[i];
        end
        return merged;
    endfunction

endpackage

// File: rtl/ram_output_stage.sv
// Read-data presentation for one RAM port: pass-through or one extra
// register stage; reset clears both data and valid in that stage.
module ram_output_stage #(
    parameter int width             = 32,
    parameter int addOutputRegister = 0
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [width-1:0] dout,
    input  logic             dout_valid,
    output logic [width-1:0] q,
    output logic             q_valid
);

    if (addOutputRegister != 0) begin : g_reg
        always_ff @(posedge clock) begin
            if (reset) begin
                q       <= '0;
                q_valid <= 1'b0;
            end else begin
                q_valid <= dout_valid;
                if (dout_valid) q <= dout;
            end
        end
    end else begin : g_pass
        assign q       = dout;
        assign q_valid = dout_valid;
    end

endmodule

// File: rtl/dual_port_ram_be.sv
// True dual-port inferred RAM with byte enables, read strobes and a
// selectable same-port read-during-write behaviour.
module dual_port_ram_be
    import ram_pkg::*;
#(
    parameter int size              = 16,
    parameter int width             = 32,
    parameter int depth             = 4,
    parameter int byteWidth         = 8,
    parameter int readMode          = 0,
    parameter int addOutputRegister = 0
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [depth-1:0]           a_address,
    input  logic [width-1:0]           a_data,
    input  logic                       a_data_valid,
    input  logic [width/byteWidth-1:0] a_byteenable,
    input  logic                       a_read,
    output logic [width-1:0]           a_q,
    output logic                       a_q_valid,
    input  logic [depth-1:0]           b_address,
    input  logic [width-1:0]           b_data,
    input  logic                       b_data_valid,
    input  logic [width/byteWidth-1:0] b_byteenable,
    input  logic                       b_read,
    output logic [width-1:0]           b_q,
    output logic                       b_q_valid
);

    localparam int LANES = lanes(width, byteWidth);
    localparam logic [depth:0] SIZE_LIM = (depth + 1)'(size);

    if (width % byteWidth != 0) begin : g_bad_lanes
        $fatal(1, "width must be a multiple of byteWidth");
    end
    if (readMode > NO_CHANGE) begin : g_bad_mode
        $fatal(1, "readMode must be 0, 1 or 2");
    end
    if ((1 << depth) < size) begin : g_bad_depth
        $fatal(1, "2^depth must cover size");
    end
    if (width > MAX_WIDTH) begin : g_bad_width
        $fatal(1, "width exceeds lane-merge limit");
    end

    logic [width-1:0] mem [2**depth];

    logic             a_in_range, b_in_range;
    logic             a_accept, b_accept;
    logic [width-1:0] a_old, b_old;
    logic [width-1:0] a_word, b_word;
    logic [width-1:0] a_dout, b_dout;
    logic             a_dout_valid, b_dout_valid;

    assign a_in_range = {1'b0, a_address} < SIZE_LIM;
    assign b_in_range = {1'b0, b_address} < SIZE_LIM;

    // No-change mode drops a read that collides with a write on its own port.
    assign a_accept = a_read && !(readMode == NO_CHANGE && a_data_valid);
    assign b_accept = b_read && !(readMode == NO_CHANGE && b_data_valid);

    assign a_old = a_in_range ? mem[a_address] : '0;
    assign b_old = b_in_range ? mem[b_address] : '0;

    always_comb begin
        a_word = a_old;
        b_word = b_old;
        if (readMode == WRITE_FIRST && a_data_valid && a_in_range) begin
            a_word = width'(mergeLanes(MAX_WIDTH'(a_old), MAX_WIDTH'(a_data),
                                       MAX_WIDTH'(a_byteenable), byteWidth));
        end
        if (readMode == WRITE_FIRST && b_data_valid && b_in_range) begin
            b_word = width'(mergeLanes(MAX_WIDTH'(b_old), MAX_WIDTH'(b_data),
                                       MAX_WIDTH'(b_byteenable), byteWidth));
        end
    end

    // Port A is applied last so it owns any lane both ports enable.
    always_ff @(posedge clock) begin
        if (!reset) begin
            if (b_data_valid && b_in_range) begin
                for (int l = 0; l < LANES; l++) begin
                    if (b_byteenable[l])
                        mem[b_address][l*byteWidth +: byteWidth] <=
                            b_data[l*byteWidth +: byteWidth];
                end
            end
            if (a_data_valid && a_in_range) begin
                for (int l = 0; l < LANES; l++) begin
                    if (a_byteenable[l])
                        mem[a_address][l*byteWidth +: byteWidth] <=
                            a_data[l*byteWidth +: byteWidth];
                end
            end
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            a_dout       <= '0;
            a_dout_valid <= 1'b0;
            b_dout       <= '0;
            b_dout_valid <= 1'b0;
        end else begin
            a_dout_valid <= a_accept;
            b_dout_valid <= b_accept;
            if (a_accept) a_dout <= a_word;
            if (b_accept) b_dout <= b_word;
        end
    end

    ram_output_stage #(
        .width             (width),
        .addOutputRegister (addOutputRegister)
    ) u_out_a (
        .clock      (clock),
        .reset      (reset),
        .dout       (a_dout),
        .dout_valid (a_dout_valid),
        .q          (a_q),
        .q_valid    (a_q_valid)
    );

    ram_output_stage #(
        .width             (width),
        .addOutputRegister (addOutputRegister)
    ) u_out_b (
        .clock      (clock),
        .reset      (reset),
        .dout       (b_dout),
        .dout_valid (b_dout_valid),
        .q          (b_q),
        .q_valid    (b_q_valid)
    );

endmodule

// File: tb/tb_dual_port_ram_be.sv
// Scoreboard bench: three RAM configurations share one stimulus stream,
// expected read data is queued per output stream and popped on q_valid.
module tb_dual_port_ram_be;

    logic        clock = 1'b0;
    logic        reset;
    logic [3:0]  a_address, b_address;
    logic [31:0] a_data, b_data;
    logic        a_data_valid, b_data_valid;
    logic [3:0]  a_byteenable, b_byteenable;
    logic        a_read, b_read;

    logic [31:0] rf_a_q, rf_b_q, wf_a_q, wf_b_q, nc_a_q, nc_b_q;
    logic        rf_a_v, rf_b_v, wf_a_v, wf_b_v, nc_a_v, nc_b_v;

    logic [31:0] exq [6][$];
    int errors = 0;
    int checks = 0;

    always #5 clock = ~clock;

    dual_port_ram_be #(
        .size(12), .width(32), .depth(4), .byteWidth(8),
        .readMode(0), .addOutputRegister(0)
    ) u_rf (
        .clock(clock), .reset(reset),
        .a_address(a_address), .a_data(a_data), .a_data_valid(a_data_valid),
        .a_byteenable(a_byteenable), .a_read(a_read),
        .a_q(rf_a_q), .a_q_valid(rf_a_v),
        .b_address(b_address), .b_data(b_data), .b_data_valid(b_data_valid),
        .b_byteenable(b_byteenable), .b_read(b_read),
        .b_q(rf_b_q), .b_q_valid(rf_b_v)
    );

    dual_port_ram_be #(
        .size(12), .width(32), .depth(4), .byteWidth(8),
        .readMode(1), .addOutputRegister(1)
    ) u_wf (
        .clock(clock), .reset(reset),
        .a_address(a_address), .a_data(a_data), .a_data_valid(a_data_valid),
        .a_byteenable(a_byteenable), .a_read(a_read),
        .a_q(wf_a_q), .a_q_valid(wf_a_v),
        .b_address(b_address), .b_data(b_data), .b_data_valid(b_data_valid),
        .b_byteenable(b_byteenable), .b_read(b_read),
        .b_q(wf_b_q), .b_q_valid(wf_b_v)
    );

    dual_port_ram_be #(
        .size(12), .width(32), .depth(4), .byteWidth(8),
        .readMode(2), .addOutputRegister(0)
    ) u_nc (
        .clock(clock), .reset(reset),
        .a_address(a_address), .a_data(a_data), .a_data_valid(a_data_valid),
        .a_byteenable(a_byteenable), .a_read(a_read),
        .a_q(nc_a_q), .a_q_valid(nc_a_v),
        .b_address(b_address), .b_data(b_data), .b_data_valid(b_data_valid),
        .b_byteenable(b_byteenable), .b_read(b_read),
        .b_q(nc_b_q), .b_q_valid(nc_b_v)
    );

    task automatic check_stream(input int k, input logic v, input logic [31:0] q);
        logic [31:0] e;
        if (v === 1'b1) begin
            checks++;
            if (exq[k].size() == 0) begin
                errors++;
                $display("FAIL stream%0d unexpected q_valid: got q=%h, required no valid", k, q);
            end else begin
                e = exq[k].pop_front();
                if (q !== e) begin
                    errors++;
                    $display("FAIL stream%0d read data: got %h, required %h", k, q, e);
                end
            end
        end
    endtask

    // Streams: 0/1 read-first A/B, 2/3 write-first+reg A/B, 4/5 no-change A/B.
    always @(negedge clock) begin
        check_stream(0, rf_a_v, rf_a_q);
        check_stream(1, rf_b_v, rf_b_q);
        check_stream(2, wf_a_v, wf_a_q);
        check_stream(3, wf_b_v, wf_b_q);
        check_stream(4, nc_a_v, nc_a_q);
        check_stream(5, nc_b_v, nc_b_q);
    end

    task automatic check_eq(input string nm, input logic [31:0] got, input logic [31:0] req);
        checks++;
        if (got !== req) begin
            errors++;
            $display("FAIL %s: got %h, required %h", nm, got, req);
        end
    endtask

    task automatic idle();
        a_address = '0; a_data = '0; a_data_valid = 0; a_byteenable = '0; a_read = 0;
        b_address = '0; b_data = '0; b_data_valid = 0; b_byteenable = '0; b_read = 0;
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic push_a(input logic [31:0] v);
        exq[0].push_back(v);
        exq[2].push_back(v);
        exq[4].push_back(v);
    endtask

    task automatic push_b(input logic [31:0] v);
        exq[1].push_back(v);
        exq[3].push_back(v);
        exq[5].push_back(v);
    endtask

    task automatic wr_a(input logic [3:0] ad, input logic [31:0] d, input logic [3:0] be);
        a_address = ad; a_data = d; a_byteenable = be; a_data_valid = 1;
    endtask

    task automatic check_all_zero(input string tag);
        check_eq({tag, " rf_a_q"}, rf_a_q, 0);
        check_eq({tag, " rf_a_v"}, 32'(rf_a_v), 0);
        check_eq({tag, " rf_b_q"}, rf_b_q, 0);
        check_eq({tag, " rf_b_v"}, 32'(rf_b_v), 0);
        check_eq({tag, " wf_a_q"}, wf_a_q, 0);
        check_eq({tag, " wf_a_v"}, 32'(wf_a_v), 0);
        check_eq({tag, " wf_b_q"}, wf_b_q, 0);
        check_eq({tag, " wf_b_v"}, 32'(wf_b_v), 0);
        check_eq({tag, " nc_a_q"}, nc_a_q, 0);
        check_eq({tag, " nc_a_v"}, 32'(nc_a_v), 0);
        check_eq({tag, " nc_b_q"}, nc_b_q, 0);
        check_eq({tag, " nc_b_v"}, 32'(nc_b_v), 0);
    endtask

    initial begin
        idle();
        reset = 1;
        step();
        step();
        @(negedge clock);
        check_all_zero("reset");
        reset = 0;

        // Write then cross-port read.
        wr_a(3, 32'h11223344, 4'hF); step(); idle();
        b_address = 3; b_read = 1; push_b(32'h11223344); step(); idle();

        // Empty byte mask leaves the word untouched.
        wr_a(3, 32'hFFFFFFFF, 4'h0); step(); idle();
        a_address = 3; a_read = 1; push_a(32'h11223344); step(); idle();

        // Single-lane write.
        wr_a(5, 32'hAABBCCDD, 4'hF); step();
        wr_a(5, 32'h00000099, 4'h1); step(); idle();
        a_address = 5; a_read = 1; b_address = 5; b_read = 1;
        push_a(32'hAABBCC99); push_b(32'hAABBCC99); step(); idle();

        // Back-to-back reads on B.
        b_address = 3; b_read = 1; push_b(32'h11223344); step();
        b_address = 5; push_b(32'hAABBCC99); step(); idle();

        // Same-port read-during-write, full word.
        wr_a(2, 32'h1, 4'hF); step(); idle(); step(); step();
        wr_a(2, 32'h2, 4'hF); a_read = 1;
        exq[0].push_back(32'h1);
        exq[2].push_back(32'h2);
        step(); idle();
        @(negedge clock);
        check_eq("nochange hold a_q", nc_a_q, 32'hAABBCC99);
        check_eq("nochange a_q_valid", 32'(nc_a_v), 0);
        a_address = 2; a_read = 1; push_a(32'h2); step(); idle();

        // Same-port read-during-write, one lane.
        wr_a(2, 32'hFFFFFFFF, 4'h1); a_read = 1;
        exq[0].push_back(32'h2);
        exq[2].push_back(32'h000000FF);
        step(); idle(); step();
        a_address = 2; a_read = 1; push_a(32'h000000FF); step(); idle();

        // Dual write collision: A owns shared lane 1.
        wr_a(7, 32'h0, 4'hF); step();
        wr_a(7, 32'h11111111, 4'h3);
        b_address = 7; b_data = 32'h22222222; b_byteenable = 4'h6; b_data_valid = 1;
        step(); idle();
        a_address = 7; a_read = 1; b_address = 7; b_read = 1;
        push_a(32'h00221111); push_b(32'h00221111); step(); idle();

        // Cross-port read sees old contents.
        wr_a(9, 32'h5, 4'hF); step();
        wr_a(9, 32'h6, 4'hF); b_address = 9; b_read = 1; push_b(32'h5); step(); idle();
        b_address = 9; b_read = 1; push_b(32'h6); step(); idle();

        // Addresses beyond size.
        wr_a(13, 32'hDEADBEEF, 4'hF); step(); idle();
        a_address = 13; a_read = 1; b_address = 12; b_read = 1;
        push_a(32'h0); push_b(32'h0); step(); idle();
        step(); step(); step();

        // Reset kills the in-flight read in the registered pipeline.
        b_address = 5; b_read = 1;
        exq[1].push_back(32'hAABBCC99);
        exq[5].push_back(32'hAABBCC99);
        step(); idle();
        reset = 1;
        step();
        @(negedge clock);
        check_all_zero("midreset");
        reset = 0;
        b_address = 5; b_read = 1; push_b(32'hAABBCC99); step(); idle();

        repeat (5) step();
        for (int k = 0; k < 6; k++) begin
            checks++;
            if (exq[k].size() != 0) begin
                errors++;
                $display("FAIL stream%0d missing reads: got %0d pending, required 0", k, exq[k].size());
            end
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
